bitonic_merge_seq: RTL and testbench



---
 rtl/bitonic_merge_seq_pkg.sv | 42 ++++
 rtl/bitonic_merge_seq_cmp_exch.sv | 22 ++
 rtl/bitonic_merge_seq.sv | 161 ++++++++++++++++
 tb/tb_bitonic_merge_seq.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bitonic_merge_seq_pkg.sv
// rtl/bitonic_merge_seq_pkg.sv - shared encodings and pass tables for the bitonic merger
// Purpose: FSM state encoding, pass count and the compare-exchange index-pair
//          tables shared by the merger top.
// Ports:   none (package).
package bitonic_merge_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_MERGE = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   localparam int NUM_PASSES = 3;
   localparam int NUM_ELEMS  = 8;
   localparam int NUM_UNITS  = 4;

   localparam logic [1:0] LAST_PASS = 2'(NUM_PASSES - 1);

   // Lower (0-based) element index handled by each compare-exchange unit.
   // Each row packs unit 3..0 from left to right, 3 bits per unit.
   function automatic logic [2:0] pair_lo(input logic [1:0] pass, input logic [1:0] unit);
      logic [11:0] row;
      case (pass)
         2'd0:    row = {3'd3, 3'd2, 3'd1, 3'd0};
         2'd1:    row = {3'd5, 3'd4, 3'd1, 3'd0};
         default: row = {3'd6, 3'd4, 3'd2, 3'd0};
      endcase
      return row[3*unit +: 3];
   endfunction

   // Higher (0-based) element index handled by each compare-exchange unit.
   function automatic logic [2:0] pair_hi(input logic [1:0] pass, input logic [1:0] unit);
      logic [11:0] row;
      case (pass)
         2'd0:    row = {3'd7, 3'd6, 3'd5, 3'd4};
         2'd1:    row = {3'd7, 3'd6, 3'd3, 3'd2};
         default: row = {3'd7, 3'd5, 3'd3, 3'd1};
      endcase
      return row[3*unit +: 3];
   endfunction

endpackage

// File: rtl/bitonic_merge_seq_cmp_exch.sv
// rtl/bitonic_merge_seq_cmp_exch.sv - combinational compare-exchange unit
// Purpose: orders one element pair; ties leave the pair untouched.
// Ports:   a/b  - lower-index / higher-index operands
//          lo/hi - results for the lower-index / higher-index positions
module bitonic_cmp_exch #(
   parameter int WIDTH   = 8,
   parameter int DESCEND = 0
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] hi
);

   logic swap;

   // Strict compare so equal values never move.
   assign swap = (DESCEND != 0) ? (a < b) : (a > b);
   assign lo   = swap ? b : a;
   assign hi   = swap ? a : b;

endmodule

// File: rtl/bitonic_merge_seq.sv
// rtl/bitonic_merge_seq.sv - sequential 8-element bitonic merger, three half-cleaner passes
// Purpose: loads one bitonic vector, resolves it with a shared bank of four
//          compare-exchange units over three cycles, holds the sorted result.
// Ports:   clk, rst_n (sync, active-low)
//          in_valid/in_ready, number_in1..8   - input vector handshake
//          out_valid/out_ready, number_out1..8 - registered sorted vector
module bitonic_merge_seq
   import bitonic_merge_seq_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int DESCEND = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] number_in1,
   input  logic [WIDTH-1:0] number_in2,
   input  logic [WIDTH-1:0] number_in3,
   input  logic [WIDTH-1:0] number_in4,
   input  logic [WIDTH-1:0] number_in5,
   input  logic [WIDTH-1:0] number_in6,
   input  logic [WIDTH-1:0] number_in7,
   input  logic [WIDTH-1:0] number_in8,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] number_out1,
   output logic [WIDTH-1:0] number_out2,
   output logic [WIDTH-1:0] number_out3,
   output logic [WIDTH-1:0] number_out4,
   output logic [WIDTH-1:0] number_out5,
   output logic [WIDTH-1:0] number_out6,
   output logic [WIDTH-1:0] number_out7,
   output logic [WIDTH-1:0] number_out8
);

   state_t           state_q, state_n;
   logic [1:0]       pass_q;
   logic             in_ready_q, out_valid_q;
   logic             load, advance;

   logic [WIDTH-1:0] data_q [NUM_ELEMS];
   logic [WIDTH-1:0] data_n [NUM_ELEMS];

   logic [WIDTH-1:0] cx_a  [NUM_UNITS];
   logic [WIDTH-1:0] cx_b  [NUM_UNITS];
   logic [WIDTH-1:0] cx_lo [NUM_UNITS];
   logic [WIDTH-1:0] cx_hi [NUM_UNITS];

   always_comb begin : fsm_next
      state_n = state_q;
      load    = 1'b0;
      advance = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (in_valid && in_ready_q) begin
               load    = 1'b1;
               state_n = ST_MERGE;
            end
         end
         ST_MERGE: begin
            advance = 1'b1;
            if (pass_q == LAST_PASS) begin
               state_n = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_n = ST_IDLE;
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   // Handshake flags are registered from the next state so that no input
   // port reaches an output port combinationally; in_ready also stays low
   // for as long as reset is held.
   always_ff @(posedge clk) begin : fsm_reg
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_n;
         in_ready_q  <= (state_n == ST_IDLE);
         out_valid_q <= (state_n == ST_DONE);
      end
   end

   // Operand routing for the current pass.
   always_comb begin : cx_select
      for (int u = 0; u < NUM_UNITS; u++) begin
         cx_a[u] = data_q[pair_lo(pass_q, 2'(u))];
         cx_b[u] = data_q[pair_hi(pass_q, 2'(u))];
      end
   end

   for (genvar u = 0; u < NUM_UNITS; u++) begin : g_cx
      bitonic_cmp_exch #(
         .WIDTH   (WIDTH),
         .DESCEND (DESCEND)
      ) u_cx (
         .a  (cx_a[u]),
         .b  (cx_b[u]),
         .lo (cx_lo[u]),
         .hi (cx_hi[u])
      );
   end

   always_comb begin : data_next
      for (int i = 0; i < NUM_ELEMS; i++) begin
         data_n[i] = data_q[i];
      end
      if (load) begin
         data_n[0] = number_in1;
         data_n[1] = number_in2;
         data_n[2] = number_in3;
         data_n[3] = number_in4;
         data_n[4] = number_in5;
         data_n[5] = number_in6;
         data_n[6] = number_in7;
         data_n[7] = number_in8;
      end else if (advance) begin
         for (int u = 0; u < NUM_UNITS; u++) begin
            data_n[pair_lo(pass_q, 2'(u))] = cx_lo[u];
            data_n[pair_hi(pass_q, 2'(u))] = cx_hi[u];
         end
      end
   end

   always_ff @(posedge clk) begin : data_reg
      if (!rst_n) begin
         pass_q <= '0;
         for (int i = 0; i < NUM_ELEMS; i++) begin
            data_q[i] <= '0;
         end
      end else begin
         if (load) begin
            pass_q <= '0;
         end else if (advance) begin
            pass_q <= pass_q + 2'd1;
         end
         for (int i = 0; i < NUM_ELEMS; i++) begin
            data_q[i] <= data_n[i];
         end
      end
   end

   assign in_ready    = in_ready_q;
   assign out_valid   = out_valid_q;
   assign number_out1 = data_q[0];
   assign number_out2 = data_q[1];
   assign number_out3 = data_q[2];
   assign number_out4 = data_q[3];
   assign number_out5 = data_q[4];
   assign number_out6 = data_q[5];
   assign number_out7 = data_q[6];
   assign number_out8 = data_q[7];

endmodule

// File: tb/tb_bitonic_merge_seq.sv
// tb/tb_bitonic_merge_seq.sv - scoreboard bench for bitonic_merge_seq, ascending and descending
module tb_bitonic_merge_seq;

   typedef logic [63:0] vec_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       out_ready = 1'b1;
   logic [7:0] nin [8];
   logic [7:0] oa  [8];
   logic [7:0] od  [8];
   logic       in_ready_a, out_valid_a, in_ready_d, out_valid_d;
   vec_t       out_a, out_d;

   int         total = 0;
   int         bad = 0;
   int         cyc = 0;
   int         ready_mode = 0;

   vec_t       qa[$];
   vec_t       qd[$];
   bit         busy = 0;
   bit         prev_valid = 0;
   bit         prev_hs = 0;
   vec_t       prev_out_a, prev_out_d;
   int         acc_last = 0;
   int         hs_last = 0;
   int         rise_last = 0;
   int         rise_prev = 0;

   bitonic_merge_seq #(.WIDTH(8), .DESCEND(0)) u_asc (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
      .number_in1(nin[0]), .number_in2(nin[1]), .number_in3(nin[2]), .number_in4(nin[3]),
      .number_in5(nin[4]), .number_in6(nin[5]), .number_in7(nin[6]), .number_in8(nin[7]),
      .out_valid(out_valid_a), .out_ready(out_ready),
      .number_out1(oa[0]), .number_out2(oa[1]), .number_out3(oa[2]), .number_out4(oa[3]),
      .number_out5(oa[4]), .number_out6(oa[5]), .number_out7(oa[6]), .number_out8(oa[7])
   );

   bitonic_merge_seq #(.WIDTH(8), .DESCEND(1)) u_desc (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_d),
      .number_in1(nin[0]), .number_in2(nin[1]), .number_in3(nin[2]), .number_in4(nin[3]),
      .number_in5(nin[4]), .number_in6(nin[5]), .number_in7(nin[6]), .number_in8(nin[7]),
      .out_valid(out_valid_d), .out_ready(out_ready),
      .number_out1(od[0]), .number_out2(od[1]), .number_out3(od[2]), .number_out4(od[3]),
      .number_out5(od[4]), .number_out6(od[5]), .number_out7(od[6]), .number_out8(od[7])
   );

   for (genvar i = 0; i < 8; i++) begin : g_pack
      assign out_a[8*i +: 8] = oa[i];
      assign out_d[8*i +: 8] = od[i];
   end

   initial forever #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = 1'b0;
         default: out_ready = 1'($urandom_range(0, 1));
      endcase
   end

   task automatic check(input string name, input vec_t act, input vec_t exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic timeout_fail(input string name);
      total++;
      bad++;
      $display("FAIL %s: timed out waiting (cycle %0d)", name, cyc);
   endtask

   // Reference: half-cleaners at strides 4, 2, 1; element i meets i+stride.
   function automatic vec_t merge_model(input vec_t v, input bit desc);
      logic [7:0] e [8];
      logic [7:0] t;
      vec_t       r;
      for (int i = 0; i < 8; i++) e[i] = v[8*i +: 8];
      for (int s = 4; s >= 1; s = s / 2) begin
         for (int i = 0; i < 8; i++) begin
            if ((i & s) == 0) begin
               if (desc ? (e[i] < e[i+s]) : (e[i] > e[i+s])) begin
                  t = e[i]; e[i] = e[i+s]; e[i+s] = t;
               end
            end
         end
      end
      for (int i = 0; i < 8; i++) r[8*i +: 8] = e[i];
      return r;
   endfunction

   function automatic vec_t mk8(input int a, b, c, d, e, f, g, h);
      return {8'(h), 8'(g), 8'(f), 8'(e), 8'(d), 8'(c), 8'(b), 8'(a)};
   endfunction

   // Monitor / scoreboard
   always @(negedge clk) begin
      bit hs;
      if (!rst_n) begin
         qa.delete();
         qd.delete();
         busy = 0;
         prev_valid = 0;
         prev_hs = 0;
      end else begin
         if (prev_hs) begin
            check("idle_in_ready", 64'(in_ready_a), 64'd1);
            check("idle_out_valid", 64'(out_valid_a), 64'd0);
         end else if (busy) begin
            check("busy_in_ready", 64'(in_ready_a), 64'd0);
         end
         if (out_valid_a && prev_valid && !prev_hs) begin
            check("hold_asc", out_a, prev_out_a);
            check("hold_desc", out_d, prev_out_d);
         end
         if (out_valid_a && !prev_valid) begin
            rise_prev = rise_last;
            rise_last = cyc;
            check("latency", 64'(cyc - acc_last), 64'd4);
         end
         hs = out_valid_a && out_ready;
         if (hs) begin
            if (qa.size() == 0) timeout_fail("asc_unexpected_output");
            else check("data_asc", out_a, qa.pop_front());
            hs_last = cyc;
            busy = 0;
         end
         if (out_valid_d && out_ready) begin
            if (qd.size() == 0) timeout_fail("desc_unexpected_output");
            else check("data_desc", out_d, qd.pop_front());
         end
         if (in_valid && in_ready_a) begin
            vec_t v;
            for (int i = 0; i < 8; i++) v[8*i +: 8] = nin[i];
            qa.push_back(merge_model(v, 1'b0));
            qd.push_back(merge_model(v, 1'b1));
            acc_last = cyc;
            busy = 1;
         end
         prev_valid = out_valid_a;
         prev_hs    = hs;
         prev_out_a = out_a;
         prev_out_d = out_d;
      end
   end

   task automatic drive(input vec_t v);
      for (int i = 0; i < 8; i++) nin[i] = v[8*i +: 8];
   endtask

   task automatic wait_in_ready(input string name);
      int k;
      for (k = 0; k < 60; k++) begin
         @(negedge clk);
         if (in_ready_a) break;
      end
      if (!in_ready_a) timeout_fail(name);
   endtask

   // Presents v and returns #1 after the accept edge.
   task automatic send(input vec_t v);
      @(posedge clk); #1;
      drive(v);
      in_valid = 1'b1;
      wait_in_ready("send_wait");
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int k;
      for (k = 0; k < 200; k++) begin
         @(negedge clk);
         if (qa.size() == 0 && qd.size() == 0 && !out_valid_a) break;
      end
      if (qa.size() != 0 || qd.size() != 0) timeout_fail("drain");
   endtask

   initial begin
      drive(64'd0);
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", 64'(in_ready_a), 64'd0);
      check("rst_out_valid", 64'(out_valid_a), 64'd0);
      check("rst_data_asc", out_a, 64'd0);
      check("rst_data_desc", out_d, 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("release_in_ready", 64'(in_ready_a), 64'd1);

      // Directed vectors
      send(mk8(1, 3, 5, 7, 8, 6, 4, 2));
      drain();
      check("asc_fixed_result", prev_out_a, mk8(1, 2, 3, 4, 5, 6, 7, 8));
      send(mk8(8, 6, 4, 2, 1, 3, 5, 7));
      drain();
      check("desc_fixed_result", prev_out_d, mk8(8, 7, 6, 5, 4, 3, 2, 1));
      send(mk8(0, 0, 255, 255, 255, 255, 0, 0));
      drain();
      check("extreme_result", prev_out_a, mk8(0, 0, 0, 0, 255, 255, 255, 255));
      send(mk8(8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80));
      drain();

      // Backpressure with ignored in_valid pulses
      ready_mode = 1;
      send({$urandom, $urandom});
      begin
         int k;
         for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (out_valid_a) break;
         end
         if (!out_valid_a) timeout_fail("bp_wait_valid");
      end
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1;
         in_valid = k[0];
         drive({$urandom, $urandom});
         @(negedge clk);
         check("bp_out_valid", 64'(out_valid_a), 64'd1);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      ready_mode = 0;
      drain();

      // Reset asserted at the pass-1 edge
      send({$urandom, $urandom});
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("midrst_out_valid", 64'(out_valid_a), 64'd0);
      check("midrst_in_ready", 64'(in_ready_a), 64'd0);
      check("midrst_data_asc", out_a, 64'd0);
      check("midrst_data_desc", out_d, 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      send(mk8(2, 4, 6, 8, 7, 5, 3, 1));
      drain();
      check("post_rst_result", prev_out_a, mk8(1, 2, 3, 4, 5, 6, 7, 8));

      // Back-to-back with in_valid held high
      @(posedge clk); #1;
      drive({$urandom, $urandom});
      in_valid = 1'b1;
      wait_in_ready("b2b_first");
      @(posedge clk); #1;
      drive(mk8(10, 20, 30, 40, 35, 25, 15, 5));
      wait_in_ready("b2b_second");
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("b2b_accept_gap", 64'(acc_last - hs_last), 64'd1);
      drain();
      check("b2b_result", prev_out_a, mk8(5, 10, 15, 20, 25, 30, 35, 40));
      check("b2b_spacing", 64'(rise_last - rise_prev), 64'd5);

      // Random vectors with random backpressure
      ready_mode = 2;
      for (int n = 0; n < 25; n++) begin
         send({$urandom, $urandom});
      end
      ready_mode = 0;
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
      $fatal(1);
   end

endmodule
